// File: rtl/ysyx_23060061_axi_sram.sv
// AXI4 slave SRAM behind the arbiter: single-beat writes, INCR read bursts, DECERR outside the mapped window.
// Optional YSYX_23060061_SRAM_RAND_DELAY_EN adds LFSR-driven per-beat latency (1..8); default latency is 1.
module ysyx_23060061_axi_sram #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  output logic        rlast,
  output logic [3:0]  rid,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned WORDS = 1 << DEPTH_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_R_WAIT, S_R_DATA, S_W_WAIT, S_B_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  beats_q, beats_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [3:0]  rid_q, rid_d;
  logic        rlast_q, rlast_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        mem_we;
  logic [3:0]  lat;

  logic [31:0] mem [WORDS];

  logic [31:0]           off;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;

  assign off      = addr_q - ADDR_BASE;
  assign in_range = (off[31:DEPTH_LOG2+2] == '0);
  assign idx      = off[DEPTH_LOG2+1:2];

  logic unused_bits;
  assign unused_bits = ^{arsize, arburst, off[1:0]};

`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 8'hA5;
    else      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end
  assign lat = {1'b0, lfsr_q[2:0]} + 4'd1;
`else
  assign lat = 4'd1;
`endif

  assign arready = rst && (state_q == S_IDLE);
  assign awready = rst && (state_q == S_IDLE) && awvalid && wvalid && !arvalid;
  assign wready  = awready;
  assign rvalid  = (state_q == S_R_DATA);
  assign bvalid  = (state_q == S_B_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;
  assign rlast   = rlast_q;
  assign bresp   = bresp_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rid_d   = rid_q;
    rlast_d = rlast_q;
    bresp_d = bresp_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arvalid) begin
          addr_d  = araddr;
          id_d    = arid;
          beats_d = arlen;
          cnt_d   = lat;
          state_d = S_R_WAIT;
        end else if (awvalid && wvalid) begin
          addr_d  = awaddr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = lat;
          state_d = S_W_WAIT;
        end
      end
      S_R_WAIT: begin
        // Counter runs down to zero, so response lands lat+1 edges after the handshake
        if (cnt_q == '0) begin
          rdata_d = in_range ? mem[idx] : '0;
          rresp_d = in_range ? 2'b00 : 2'b11;
          rid_d   = id_q;
          rlast_d = (beats_q == '0);
          state_d = S_R_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + 32'd4;
            beats_d = beats_q - 8'd1;
            cnt_d   = lat;
            state_d = S_R_WAIT;
          end
        end
      end
      S_W_WAIT: begin
        if (cnt_q == '0) begin
          mem_we  = in_range;
          bresp_d = in_range ? 2'b00 : 2'b11;
          state_d = S_B_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_B_RESP: begin
        if (bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      id_q    <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      rid_q   <= '0;
      rlast_q <= 1'b0;
      bresp_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      rid_q   <= rid_d;
      rlast_q <= rlast_d;
      bresp_q <= bresp_d;
    end
  end

  // Storage has no reset so contents survive rst; writes only fire from W_WAIT
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_axi_sram.sv
// Scoreboard bench for ysyx_23060061_axi_sram: stimulus pushes expected R/B responses, a negedge monitor pops and checks.
module tb_ysyx_23060061_axi_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic        rlast;
  logic [3:0]  rid;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;

  always #5 clk = ~clk;

  ysyx_23060061_axi_sram #(.ADDR_BASE(32'h8000_0000), .DEPTH_LOG2(12)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rid(rid),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
  } rbeat_t;

  rbeat_t     r_q[$];
  logic [1:0] b_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever a response handshake will occur on the next edge
  logic        stall_prev = 1'b0;
  logic [31:0] prev_d = '0;
  logic [6:0]  prev_ctl = '0;
  always @(negedge clk) begin
    if (rst && rvalid && stall_prev) begin
      chk("r_stable_data", rdata, prev_d);
      chk("r_stable_ctl", 32'({rresp, rid, rlast}), 32'(prev_ctl));
    end
    if (rst && rvalid && rready) begin
      if (r_q.size() == 0) begin
        total++; bad++;
        $display("FAIL r_unexpected: got rdata %h with no expected beat", rdata);
      end else begin
        rbeat_t e;
        e = r_q.pop_front();
        chk("rdata", rdata, e.d);
        chk("rresp", 32'(rresp), 32'(e.resp));
        chk("rid", 32'(rid), 32'(e.id));
        chk("rlast", 32'(rlast), 32'(e.last));
      end
    end
    if (rst && bvalid && bready) begin
      if (b_q.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: got bresp %b with no expected response", bresp);
      end else begin
        logic [1:0] eb;
        eb = b_q.pop_front();
        chk("bresp", 32'(bresp), 32'(eb));
      end
    end
    stall_prev <= rst && rvalid && !rready;
    prev_d     <= rdata;
    prev_ctl   <= {rresp, rid, rlast};
  end

  task automatic exp_r(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id, input logic last);
    rbeat_t e;
    e.d = d; e.resp = resp; e.id = id; e.last = last;
    r_q.push_back(e);
  endtask

  task automatic ar_issue(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id);
    bit ok = 0;
    araddr = a; arlen = len; arid = id; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    chk("ar_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  // Edges from the handshake edge until valid rises: latency + 1
  task automatic wait_lat(input bit is_read);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(is_read ? rvalid : bvalid) && n < 40);
`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
    chk(is_read ? "r_latency_range" : "b_latency_range", 32'(n >= 2 && n <= 9), 32'd1);
`else
    chk(is_read ? "r_latency" : "b_latency", 32'(n), 32'd2);
`endif
  endtask

  task automatic drain_r(input bit toggle);
    int n = 0;
    while (r_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (toggle) rready = ~rready;
    end
    chk("r_drain", 32'(r_q.size()), 32'd0);
    rready = 1'b1;
  endtask

  task automatic drain_b();
    int n = 0;
    while (b_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b_drain", 32'(b_q.size()), 32'd0);
    chk("bvalid_one_cycle", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [3:0] id, input bit toggle);
    ar_issue(a, len, id);
    wait_lat(1'b1);
    drain_r(toggle);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] resp);
    bit ok = 0;
    b_q.push_back(resp);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    chk("aw_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_lat(1'b0);
    drain_b();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset: readies stay low even with requests pending
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rlast", 32'(rlast), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Full-word write and readback
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
    exp_r(32'hDEAD_BEEF, 2'b00, 4'h2, 1'b1);
    do_read(32'h8000_0010, 8'd0, 4'h2, 1'b0);

    // Byte-strobed merge
    do_write(32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00);
    do_write(32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00);
    exp_r(32'h11BB_33DD, 2'b00, 4'h3, 1'b1);
    do_read(32'h8000_0020, 8'd0, 4'h3, 1'b0);

    // Four-beat burst with back-pressure
    do_write(32'h8000_0000, 32'h1000_0001, 4'hF, 2'b00);
    do_write(32'h8000_0004, 32'h2000_0002, 4'hF, 2'b00);
    do_write(32'h8000_0008, 32'h3000_0003, 4'hF, 2'b00);
    do_write(32'h8000_000C, 32'h4000_0004, 4'hF, 2'b00);
    exp_r(32'h1000_0001, 2'b00, 4'h5, 1'b0);
    exp_r(32'h2000_0002, 2'b00, 4'h5, 1'b0);
    exp_r(32'h3000_0003, 2'b00, 4'h5, 1'b0);
    exp_r(32'h4000_0004, 2'b00, 4'h5, 1'b1);
    rready = 1'b0;
    do_read(32'h8000_0000, 8'd3, 4'h5, 1'b1);

    // Simultaneous read and write requests: read wins, write follows
    exp_r(32'h11BB_33DD, 2'b00, 4'h6, 1'b1);
    b_q.push_back(2'b00);
    araddr = 32'h8000_0020; arlen = 8'd0; arid = 4'h6; arvalid = 1'b1;
    awaddr = 32'h8000_0030; wdata = 32'h55AA_55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("arb_arready", 32'(arready), 32'd1);
    chk("arb_awready", 32'(awready), 32'd0);
    chk("arb_wready", 32'(wready), 32'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    begin
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (awready && wready) begin ok = 1; break; end
      end
      chk("arb_write_accepted", 32'(ok), 32'd1);
      chk("arb_read_done_first", 32'(r_q.size()), 32'd0);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    drain_b();
    exp_r(32'h55AA_55AA, 2'b00, 4'h6, 1'b1);
    do_read(32'h8000_0030, 8'd0, 4'h6, 1'b0);

    // Out-of-range accesses and a burst running off the top of the window
    exp_r(32'h0, 2'b11, 4'h7, 1'b1);
    do_read(32'h0000_1000, 8'd0, 4'h7, 1'b0);
    exp_r(32'h0, 2'b11, 4'h7, 1'b1);
    do_read(32'h7FFF_FFFC, 8'd0, 4'h7, 1'b0);
    do_write(32'h9000_0000, 32'hDEAD_BEEF, 4'hF, 2'b11);
    exp_r(32'h1000_0001, 2'b00, 4'h8, 1'b1);
    do_read(32'h8000_0000, 8'd0, 4'h8, 1'b0);
    do_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 2'b00);
    exp_r(32'hCAFE_F00D, 2'b00, 4'h9, 1'b0);
    exp_r(32'h0, 2'b11, 4'h9, 1'b1);
    do_read(32'h8000_3FFC, 8'd1, 4'h9, 1'b0);

    // Reset while a beat is parked in R_DATA
    rready = 1'b0;
    ar_issue(32'h8000_0010, 8'd0, 4'hA);
    wait_lat(1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_arready", 32'(arready), 32'd0);
    r_q.delete();
    rready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("postrst_idle_arready", 32'(arready), 32'd1);
    chk("postrst_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
    exp_r(32'hDEAD_BEEF, 2'b00, 4'hB, 1'b1);
    do_read(32'h8000_0010, 8'd0, 4'hB, 1'b0);
    exp_r(32'h11BB_33DD, 2'b00, 4'hC, 1'b1);
    do_read(32'h8000_0020, 8'd0, 4'hC, 1'b0);
    exp_r(32'h55AA_55AA, 2'b00, 4'hD, 1'b1);
    do_read(32'h8000_0030, 8'd0, 4'hD, 1'b0);

    repeat (3) @(posedge clk);
    chk("final_r_queue", 32'(r_q.size()), 32'd0);
    chk("final_b_queue", 32'(b_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
